// File: rtl/axi_apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_apb_pkg: shared types and defaults for the AXI-APB bridge.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package axi_apb_pkg;

  localparam int c_data_width    = 32;
  localparam int c_pointer_width = 3;
  localparam int c_len_width     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DRAIN  = 2'd2
  } wbuf_state_e;

  // Stored beat layout is {last, strb, data}.
  function automatic int wbeat_width(input int data_width);
    return data_width + data_width / 8 + 1;
  endfunction

  localparam int c_wbeat_width = wbeat_width(c_data_width);

endpackage
`default_nettype wire

// File: rtl/axi_wdata_buffer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wbeat_fifo: single-clock first-word-fall-through beat FIFO.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wbeat_fifo #(
  parameter int WIDTH         = 37,
  parameter int POINTER_WIDTH = 3
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int c_depth = 2 ** POINTER_WIDTH;

  logic [WIDTH-1:0]       r_mem [c_depth];
  logic [POINTER_WIDTH:0] r_wr_ptr;
  logic [POINTER_WIDTH:0] r_rd_ptr;
  logic                   w_push;
  logic                   w_pop;

  assign full  = (r_wr_ptr[POINTER_WIDTH] != r_rd_ptr[POINTER_WIDTH]) &&
                 (r_wr_ptr[POINTER_WIDTH-1:0] == r_rd_ptr[POINTER_WIDTH-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge wclk) begin
    if (w_push) r_mem[r_wr_ptr[POINTER_WIDTH-1:0]] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr[POINTER_WIDTH-1:0]];

endmodule
`default_nettype wire

// File: rtl/axi_wdata_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_wdata_buffer: AXI W-channel burst receiver feeding the APB side. |
// | Optional macro WLAST_CHECK_EN adds the sticky wlast_err check.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axi_wdata_buffer
  import axi_apb_pkg::*;
#(
  parameter int DATA_WIDTH    = c_data_width,
  parameter int POINTER_WIDTH = c_pointer_width,
  parameter int LEN_WIDTH     = c_len_width
) (
  input  logic                    wclk,
  input  logic                    rst_n,
  input  logic                    burst_start,
  input  logic [LEN_WIDTH-1:0]    burst_len,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    beat_avail,
  input  logic                    beat_rd,
  output logic [DATA_WIDTH-1:0]   beat_data,
  output logic [DATA_WIDTH/8-1:0] beat_strb,
  output logic                    beat_last,
`ifdef WLAST_CHECK_EN
  output logic                    wlast_err,
`endif
  output logic                    burst_done
);

  localparam int c_beat_width = wbeat_width(DATA_WIDTH);

  wbuf_state_e            r_state;
  wbuf_state_e            w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic                   r_burst_done;
  logic                   w_wready;
  logic                   w_push;
  logic                   w_last_beat;
  logic                   w_full;
  logic                   w_empty;
  logic [c_beat_width-1:0] w_rd_beat;

  assign w_last_beat = (r_cnt == r_len);
  assign w_push      = wvalid & w_wready;

  always_comb begin
    w_state_nxt = r_state;
    w_wready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (burst_start) w_state_nxt = ACCEPT;
      end
      ACCEPT: begin
        w_wready = ~w_full;
        if (w_push && w_last_beat) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_burst_done <= (r_state == DRAIN) && w_empty;
      if (r_state == IDLE && burst_start) begin
        r_len <= burst_len;
        r_cnt <= '0;
      end else if (w_push) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef WLAST_CHECK_EN
  logic r_wlast_err;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wlast_err <= 1'b0;
    end else if (r_state == IDLE && burst_start) begin
      r_wlast_err <= 1'b0;
    end else if (w_push && (wlast != w_last_beat)) begin
      r_wlast_err <= 1'b1;
    end
  end

  assign wlast_err = r_wlast_err;
`else
  logic w_unused_wlast;
  assign w_unused_wlast = wlast;
`endif

  wbeat_fifo #(
    .WIDTH         (c_beat_width),
    .POINTER_WIDTH (POINTER_WIDTH)
  ) u_fifo (
    .wclk    (wclk),
    .rst_n   (rst_n),
    .push    (w_push),
    .wr_data ({w_last_beat, wstrb, wdata}),
    .pop     (beat_rd),
    .rd_data (w_rd_beat),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign wready     = w_wready;
  assign beat_avail = ~w_empty;
  assign beat_data  = w_rd_beat[DATA_WIDTH-1:0];
  assign beat_strb  = w_rd_beat[DATA_WIDTH+DATA_WIDTH/8-1:DATA_WIDTH];
  assign beat_last  = w_rd_beat[c_beat_width-1];
  assign burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_axi_wdata_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_wdata_buffer: directed self-checking bench for the W buffer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_axi_wdata_buffer;

  logic        wclk = 1'b0;
  logic        rst_n;
  logic        burst_start;
  logic [7:0]  burst_len;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        beat_avail;
  logic        beat_rd;
  logic [31:0] beat_data;
  logic [3:0]  beat_strb;
  logic        beat_last;
  logic        burst_done;
`ifdef WLAST_CHECK_EN
  logic        wlast_err;
`endif

  always #5 wclk = ~wclk;

  axi_wdata_buffer dut (
    .wclk        (wclk),
    .rst_n       (rst_n),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .beat_avail  (beat_avail),
    .beat_rd     (beat_rd),
    .beat_data   (beat_data),
    .beat_strb   (beat_strb),
    .beat_last   (beat_last),
`ifdef WLAST_CHECK_EN
    .wlast_err   (wlast_err),
`endif
    .burst_done  (burst_done)
  );

  typedef struct {
    logic        bs;
    logic [7:0]  len;
    logic        wv;
    logic [31:0] wd;
    logic        wl;
    logic        rd;
    logic        e_wready;
    logic        e_avail;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_done;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  vec_t        tbl [9];
  exp_t        sb [$];
  int          g_sent;
  int          g_len;
  int          g_bad_idx;
  int          g_done;
  logic        g_ign;
  logic [31:0] g_base;
  logic [3:0]  g_strb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    burst_start = 1'b0;
    burst_len   = 8'd0;
    wvalid      = 1'b0;
    wdata       = 32'd0;
    wstrb       = 4'd0;
    wlast       = 1'b0;
    beat_rd     = 1'b0;
  endtask

  task automatic start_burst(input int len);
    @(negedge wclk);
    idle_inputs();
    burst_start = 1'b1;
    burst_len   = 8'(len);
    #1;
    chk("start_wready", 64'(wready), 64'd0);
    g_len  = len;
    g_sent = 0;
    g_done = 0;
    sb.delete();
  endtask

  // Feeds remaining beats, drains with beat_rd=1 and checks order against the scoreboard.
  task automatic pump();
    logic prev_avail;
    int   post;
    exp_t e;
    prev_avail = 1'b0;
    post = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge wclk);
      burst_start = g_ign && ((g_sent <= g_len) || prev_avail);
      burst_len   = 8'(g_len + 4);
      wvalid      = (g_sent <= g_len);
      wdata       = g_base + 32'(g_sent);
      wstrb       = g_strb;
      wlast       = (g_sent == g_len) ^ (g_sent == g_bad_idx);
      beat_rd     = 1'b1;
      #1;
      if (beat_avail) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 64'(beat_avail), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("pop_data", 64'(beat_data), 64'(e.d));
          chk("pop_strb", 64'(beat_strb), 64'(e.s));
          chk("pop_last", 64'(beat_last), 64'(e.l));
        end
      end
      if (wvalid && wready) begin
        sb.push_back('{wdata, wstrb, logic'(g_sent == g_len)});
        g_sent++;
      end
      if (burst_done) g_done++;
      prev_avail = beat_avail;
      if (g_done > 0) begin
        post++;
        if (post > 3) break;
      end
    end
    @(negedge wclk);
    idle_inputs();
    chk("done_count", 64'(g_done), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("beats_sent", 64'(g_sent), 64'(g_len + 1));
  endtask

  task automatic run_burst(input int len, input logic [31:0] base, input logic [3:0] strb,
                           input int bad_idx);
    g_base    = base;
    g_strb    = strb;
    g_bad_idx = bad_idx;
    start_burst(len);
    pump();
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd3, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'd0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'd0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0};

    g_ign = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_avail", 64'(beat_avail), 64'd0);
    chk("rst_done", 64'(burst_done), 64'd0);
`ifdef WLAST_CHECK_EN
    chk("rst_wlast_err", 64'(wlast_err), 64'd0);
`endif
    @(negedge wclk);
    rst_n = 1'b1;

    // Four back-to-back beats with continuous draining.
    for (int i = 0; i < 9; i++) begin
      @(negedge wclk);
      burst_start = tbl[i].bs;
      burst_len   = tbl[i].len;
      wvalid      = tbl[i].wv;
      wdata       = tbl[i].wd;
      wstrb       = 4'hF;
      wlast       = tbl[i].wl;
      beat_rd     = tbl[i].rd;
      #1;
      chk($sformatf("t%0d_wready", i), 64'(wready), 64'(tbl[i].e_wready));
      chk($sformatf("t%0d_avail", i), 64'(beat_avail), 64'(tbl[i].e_avail));
      chk($sformatf("t%0d_done", i), 64'(burst_done), 64'(tbl[i].e_done));
      if (tbl[i].e_avail) begin
        chk($sformatf("t%0d_data", i), 64'(beat_data), 64'(tbl[i].e_data));
        chk($sformatf("t%0d_last", i), 64'(beat_last), 64'(tbl[i].e_last));
      end
    end

    // Ten-beat burst against an eight-deep FIFO, no draining until full.
    g_base = 32'd1; g_strb = 4'hF; g_bad_idx = -1;
    start_burst(9);
    for (int i = 0; i < 8; i++) begin
      @(negedge wclk);
      wvalid = 1'b1; wdata = g_base + 32'(g_sent); wstrb = g_strb; wlast = 1'b0; beat_rd = 1'b0;
      #1;
      chk("fill_wready", 64'(wready), 64'd1);
      if (wvalid && wready) begin
        sb.push_back('{wdata, wstrb, 1'b0});
        g_sent++;
      end
    end
    @(negedge wclk);
    wdata = g_base + 32'(g_sent);
    #1;
    chk("full_wready", 64'(wready), 64'd0);
    chk("full_avail", 64'(beat_avail), 64'd1);
    @(negedge wclk);
    beat_rd = 1'b1;
    #1;
    chk("pop_full_wready", 64'(wready), 64'd0);
    chk("pop_full_data", 64'(beat_data), 64'(sb[0].d));
    void'(sb.pop_front());
    @(negedge wclk);
    beat_rd = 1'b0;
    #1;
    chk("refill_wready", 64'(wready), 64'd1);
    if (wvalid && wready) begin
      sb.push_back('{wdata, wstrb, 1'b0});
      g_sent++;
    end
    pump();

    // Single-beat burst with a partial strobe.
    run_burst(0, 32'hDEADBEEF, 4'hA, -1);

    // Reset with three beats buffered.
    g_base = 32'h200; g_strb = 4'hF; g_bad_idx = -1;
    start_burst(7);
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      wvalid = 1'b1; wdata = g_base + 32'(i); wstrb = 4'hF; beat_rd = 1'b0;
    end
    @(negedge wclk);
    rst_n = 1'b0;
    #1;
    chk("midrst_avail", 64'(beat_avail), 64'd0);
    chk("midrst_wready", 64'(wready), 64'd0);
    @(negedge wclk);
    idle_inputs();
    rst_n = 1'b1;
    run_burst(1, 32'h100, 4'h3, -1);

    // burst_start pulsed with a wrong length during ACCEPT and DRAIN.
    g_ign = 1'b1;
    run_burst(1, 32'h500, 4'hC, -1);
    g_ign = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge wclk);
      wvalid = 1'b1;
      #1;
      chk("post_ign_wready", 64'(wready), 64'd0);
    end
    @(negedge wclk);
    idle_inputs();

`ifdef WLAST_CHECK_EN
    run_burst(2, 32'h700, 4'hF, 1);
    chk("wlast_err_set", 64'(wlast_err), 64'd1);
    repeat (3) @(negedge wclk);
    #1;
    chk("wlast_err_sticky", 64'(wlast_err), 64'd1);
    run_burst(1, 32'h800, 4'hF, -1);
    chk("wlast_err_clear", 64'(wlast_err), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
